// File: rtl/pbus_pkg.sv
// Shared types and constants for the two-master PBus arbiter.
package pbus_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned BE_W   = 2;
  localparam int unsigned CNT_W  = 8;

  localparam int unsigned REQ_STROBE = 0;
  localparam int unsigned REQ_READ   = 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  typedef struct packed {
    logic              rnw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } pbus_cmd_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; a tie goes to the master not granted last.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_l,
  input  logic [1:0] req,
  input  logic       upd,
  output logic       vld_c,
  output logic       gnt_c
);

  logic last_q;

  always_comb begin
    vld_c = |req;
    gnt_c = req[1];
    if (req == 2'b11) gnt_c = ~last_q;
  end

  // Reset value 1 lets master 0 win the first tie.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)   last_q <= 1'b1;
    else if (upd) last_q <= gnt_c;
  end

endmodule

// File: rtl/pbus_arbiter.sv
// Two-master PBus arbiter/sequencer: grants round-robin, runs the
// strobe / ready handshake to the single target, and aborts on timeout.
module pbus_arbiter
  import pbus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        m0_req,
  input  logic        m0_rnw,
  input  logic [4:0]  m0_addr,
  input  logic [15:0] m0_wdata,
  input  logic [1:0]  m0_be,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [15:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_rnw,
  input  logic [4:0]  m1_addr,
  input  logic [15:0] m1_wdata,
  input  logic [1:0]  m1_be,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [15:0] m1_rdata,
  output logic [4:0]  s_addr,
  output logic [15:0] s_wdata,
  output logic [1:0]  s_be,
  output logic [1:0]  s_req,
  input  logic [15:0] s_rdata,
  input  logic        s_rdy,
  output logic        busy
);

  logic [1:0]        state_q, state_nx;
  pbus_cmd_t         cmd_q, cmd_nx, m0_cmd_c, m1_cmd_c;
  logic              gnt_q, gnt_nx;
  logic [CNT_W-1:0]  cnt_q, cnt_nx;
  logic              seen_q, seen_nx;
  logic              strobe_q, strobe_nx;
  logic [1:0]        ack_nx, err_nx;
  logic [DATA_W-1:0] rd0_nx, rd1_nx;
  logic              busy_nx;
  logic              arb_vld_c, arb_gnt_c, arb_upd_c;

  assign m0_cmd_c = {m0_rnw, m0_addr, m0_wdata, m0_be};
  assign m1_cmd_c = {m1_rnw, m1_addr, m1_wdata, m1_be};

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst_l (rst_l),
    .req   ({m1_req, m0_req}),
    .upd   (arb_upd_c),
    .vld_c (arb_vld_c),
    .gnt_c (arb_gnt_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_nx  = state_q;
    cmd_nx    = cmd_q;
    gnt_nx    = gnt_q;
    cnt_nx    = cnt_q;
    seen_nx   = seen_q;
    strobe_nx = 1'b0;
    ack_nx    = 2'b00;
    err_nx    = 2'b00;
    rd0_nx    = m0_rdata;
    rd1_nx    = m1_rdata;
    arb_upd_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (s_rdy && arb_vld_c) begin
          arb_upd_c = 1'b1;
          gnt_nx    = arb_gnt_c;
          cmd_nx    = arb_gnt_c ? m1_cmd_c : m0_cmd_c;
          strobe_nx = 1'b1;
          state_nx  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_nx   = '0;
        seen_nx  = 1'b0;
        state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (!s_rdy) seen_nx = 1'b1;
        // Ready only counts once the target has been seen busy.
        if (s_rdy && seen_q) begin
          if (cmd_q.rnw) begin
            if (gnt_q) rd1_nx = s_rdata;
            else       rd0_nx = s_rdata;
          end
          ack_nx[gnt_q] = 1'b1;
          state_nx      = ST_RELEASE;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          err_nx[gnt_q] = 1'b1;
          state_nx      = ST_RELEASE;
        end else begin
          cnt_nx = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase

    busy_nx = (state_nx != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q  <= ST_IDLE;
      cmd_q    <= '0;
      gnt_q    <= 1'b0;
      cnt_q    <= '0;
      seen_q   <= 1'b0;
      strobe_q <= 1'b0;
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_err   <= 1'b0;
      m1_err   <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_nx;
      cmd_q    <= cmd_nx;
      gnt_q    <= gnt_nx;
      cnt_q    <= cnt_nx;
      seen_q   <= seen_nx;
      strobe_q <= strobe_nx;
      m0_ack   <= ack_nx[0];
      m1_ack   <= ack_nx[1];
      m0_err   <= err_nx[0];
      m1_err   <= err_nx[1];
      m0_rdata <= rd0_nx;
      m1_rdata <= rd1_nx;
      busy     <= busy_nx;
    end
  end

  assign s_addr  = cmd_q.addr;
  assign s_wdata = cmd_q.wdata;
  assign s_be    = cmd_q.be;

  always_comb begin
    s_req             = 2'b00;
    s_req[REQ_STROBE] = strobe_q;
    s_req[REQ_READ]   = cmd_q.rnw;
  end

endmodule

// File: tb/tb_pbus_arbiter.sv
// Directed bench for pbus_arbiter with a behavioural PBus target model.
module tb_pbus_arbiter;

  logic        clk, rst_l;
  logic        m0_req, m0_rnw, m1_req, m1_rnw;
  logic [4:0]  m0_addr, m1_addr;
  logic [15:0] m0_wdata, m1_wdata;
  logic [1:0]  m0_be, m1_be;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [15:0] m0_rdata, m1_rdata;
  logic [4:0]  s_addr;
  logic [15:0] s_wdata, s_rdata;
  logic [1:0]  s_be, s_req;
  logic        s_rdy, busy;

  int          n_checks = 0;
  int          n_errors = 0;
  logic        stuck;
  logic [15:0] mem [32];
  logic [1:0]  phase;
  logic [15:0] exp_rd [2];

  pbus_arbiter #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_l(rst_l),
    .m0_req(m0_req), .m0_rnw(m0_rnw), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_be(m0_be), .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_rnw(m1_rnw), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_be(m1_be), .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_be(s_be), .s_req(s_req),
    .s_rdata(s_rdata), .s_rdy(s_rdy), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Target: busy one cycle after the strobe, write commits then; 'stuck' holds it busy.
  assign s_rdata = mem[s_addr];
  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      s_rdy <= 1'b1;
      phase <= 2'd0;
      for (int i = 0; i < 32; i++) mem[i] <= 16'h0000;
    end else begin
      case (phase)
        2'd0: if (s_req[0]) begin s_rdy <= 1'b0; phase <= 2'd1; end
        2'd1: begin
          if (!s_req[1]) begin
            if (s_be[0]) mem[s_addr][7:0]  <= s_wdata[7:0];
            if (s_be[1]) mem[s_addr][15:8] <= s_wdata[15:8];
          end
          if (stuck) phase <= 2'd2;
          else begin s_rdy <= 1'b1; phase <= 2'd0; end
        end
        default: if (!stuck) begin s_rdy <= 1'b1; phase <= 2'd0; end
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_m(input int m, input logic req, input logic rnw,
                       input logic [4:0] addr, input logic [15:0] wdata, input logic [1:0] be);
    if (m == 0) begin
      m0_req = req; m0_rnw = rnw; m0_addr = addr; m0_wdata = wdata; m0_be = be;
    end else begin
      m1_req = req; m1_rnw = rnw; m1_addr = addr; m1_wdata = wdata; m1_be = be;
    end
  endtask

  // One transfer; cycle 0 is the IDLE cycle where the request is first seen.
  task automatic xfer(input int m, input logic rnw, input logic [4:0] addr,
                      input logic [15:0] wdata, input logic [1:0] be, input int drop_at,
                      output int ack_c, output int err_c);
    int  c;
    logic done;
    ack_c = -1; err_c = -1; c = 0; done = 1'b0;
    @(posedge clk); #1;
    set_m(m, 1'b1, rnw, addr, wdata, be);
    while (!done && c < 40) begin
      if (c == drop_at) set_m(m, 1'b0, ~rnw, ~addr, ~wdata, ~be);
      @(negedge clk);
      if (c == 1) begin
        chk("issue_s_req", 32'(s_req), 32'({rnw, 1'b1}));
        chk("issue_cmd", 32'({s_addr, s_wdata, s_be}), 32'({addr, wdata, be}));
      end
      if (c == 2) chk("strobe_one_cycle", 32'(s_req[0]), 32'd0);
      if (c == 3) chk("cmd_stable", 32'({s_addr, s_wdata, s_be}), 32'({addr, wdata, be}));
      if ((m == 0 ? m0_ack : m1_ack) === 1'b1) begin ack_c = c; done = 1'b1; end
      if ((m == 0 ? m0_err : m1_err) === 1'b1) begin err_c = c; done = 1'b1; end
      if (!done) begin @(posedge clk); #1; c++; end
    end
    if (!done) chk("xfer_hang", 32'(c), 32'd0);
    @(posedge clk); #1;
    set_m(m, 1'b0, rnw, addr, wdata, be);
  endtask

  typedef struct {
    int          m;
    logic        rnw;
    logic [4:0]  addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [10];
  int   a0 [4], a1 [4];
  int   n0, n1, nerr, ack_c, err_c;

  initial begin
    vecs[0] = '{0, 1'b0, 5'h02, 16'hA5C3, 2'b11, 16'h0000};
    vecs[1] = '{0, 1'b1, 5'h02, 16'h0000, 2'b11, 16'hA5C3};
    vecs[2] = '{1, 1'b0, 5'h00, 16'h1234, 2'b01, 16'h0000};
    vecs[3] = '{1, 1'b1, 5'h00, 16'h0000, 2'b11, 16'h0034};
    vecs[4] = '{1, 1'b0, 5'h00, 16'hABCD, 2'b10, 16'h0000};
    vecs[5] = '{0, 1'b1, 5'h00, 16'h0000, 2'b11, 16'hAB34};
    vecs[6] = '{1, 1'b0, 5'h1F, 16'hFFFF, 2'b11, 16'h0000};
    vecs[7] = '{0, 1'b0, 5'h1F, 16'h0000, 2'b00, 16'h0000};
    vecs[8] = '{1, 1'b1, 5'h1F, 16'h0000, 2'b11, 16'hFFFF};
    vecs[9] = '{0, 1'b1, 5'h04, 16'h0000, 2'b11, 16'h5555};

    rst_l = 1'b0; stuck = 1'b0;
    set_m(0, 1'b0, 1'b0, 5'h00, 16'h0000, 2'b00);
    set_m(1, 1'b0, 1'b0, 5'h00, 16'h0000, 2'b00);
    exp_rd[0] = 16'h0000; exp_rd[1] = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_s_bus", 32'({s_req, s_addr, s_wdata, s_be}), 32'd0);
    chk("rst_ack_err", 32'({m0_ack, m0_err, m1_ack, m1_err}), 32'd0);
    chk("rst_m0_rdata", 32'(m0_rdata), 32'd0);
    chk("rst_m1_rdata", 32'(m1_rdata), 32'd0);
    @(posedge clk); #1;
    rst_l = 1'b1;

    // Contention from reset: continuous requests alternate m0, m1, m0, m1.
    set_m(0, 1'b1, 1'b1, 5'h02, 16'h0000, 2'b11);
    set_m(1, 1'b1, 1'b0, 5'h04, 16'h5555, 2'b11);
    n0 = 0; n1 = 0; nerr = 0;
    for (int c = 0; c < 24; c++) begin
      if (c == 20) begin m0_req = 1'b0; m1_req = 1'b0; end
      @(negedge clk);
      if (m0_ack && n0 < 4) begin a0[n0] = c; n0++; end
      if (m1_ack && n1 < 4) begin a1[n1] = c; n1++; end
      if (m0_err || m1_err) nerr++;
      @(posedge clk); #1;
    end
    chk("cont_m0_count", 32'(n0), 32'd2);
    chk("cont_m1_count", 32'(n1), 32'd2);
    if (n0 >= 2) begin
      chk("cont_m0_ack1", 32'(a0[0]), 32'd4);
      chk("cont_m0_ack2", 32'(a0[1]), 32'd14);
    end
    if (n1 >= 2) begin
      chk("cont_m1_ack1", 32'(a1[0]), 32'd9);
      chk("cont_m1_ack2", 32'(a1[1]), 32'd19);
    end
    chk("cont_no_err", 32'(nerr), 32'd0);
    chk("cont_m0_rdata", 32'(m0_rdata), 32'h0000);

    // Table of single-master transfers against a tracked memory image.
    for (int i = 0; i < 10; i++) begin
      xfer(vecs[i].m, vecs[i].rnw, vecs[i].addr, vecs[i].wdata, vecs[i].be, -1, ack_c, err_c);
      chk($sformatf("vec%0d_ack_cycle", i), 32'(ack_c), 32'd4);
      chk($sformatf("vec%0d_no_err", i), 32'(err_c), 32'hFFFF_FFFF);
      if (vecs[i].rnw) exp_rd[vecs[i].m] = vecs[i].exp_rdata;
      chk($sformatf("vec%0d_m0_rdata", i), 32'(m0_rdata), 32'(exp_rd[0]));
      chk($sformatf("vec%0d_m1_rdata", i), 32'(m1_rdata), 32'(exp_rd[1]));
    end

    // Request withdrawn (and fields scrambled) after ISSUE.
    xfer(0, 1'b1, 5'h02, 16'h0000, 2'b11, 2, ack_c, err_c);
    chk("withdraw_ack_cycle", 32'(ack_c), 32'd4);
    chk("withdraw_rdata", 32'(m0_rdata), 32'hA5C3);
    exp_rd[0] = 16'hA5C3;

    // Target never comes ready: error pulse at TIMEOUT+3, no ack, rdata held.
    stuck = 1'b1;
    xfer(0, 1'b1, 5'h00, 16'h0000, 2'b11, -1, ack_c, err_c);
    stuck = 1'b0;
    chk("timeout_err_cycle", 32'(err_c), 32'd19);
    chk("timeout_no_ack", 32'(ack_c), 32'hFFFF_FFFF);
    chk("timeout_rdata_held", 32'(m0_rdata), 32'hA5C3);
    xfer(1, 1'b1, 5'h00, 16'h0000, 2'b11, -1, ack_c, err_c);
    chk("after_timeout_ack", 32'(ack_c), 32'd4);
    chk("after_timeout_rdata", 32'(m1_rdata), 32'hAB34);

    // Reset asserted in the first WAIT cycle of a write.
    @(posedge clk); #1;
    set_m(0, 1'b1, 1'b0, 5'h03, 16'h1111, 2'b11);
    repeat (2) @(posedge clk);
    #1 rst_l = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_s_bus", 32'({s_req, s_addr, s_wdata, s_be}), 32'd0);
    chk("midrst_rdata", 32'({m0_rdata, m1_rdata}), 32'd0);
    m0_req = 1'b0;
    @(posedge clk); #1;
    rst_l = 1'b1;
    @(negedge clk);
    chk("midrst_idle", 32'(busy), 32'd0);
    xfer(1, 1'b1, 5'h03, 16'h0000, 2'b11, -1, ack_c, err_c);
    chk("midrst_next_ack", 32'(ack_c), 32'd4);
    chk("midrst_next_rdata", 32'(m1_rdata), 32'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pbus_arbiter.md
# pbus_arbiter

Two-master arbiter and sequencer for the 16-bit peripheral bus (PBus) in front of the I/O controller. It accepts level requests from master 0 (CPU load/store unit) and master 1 (debug/COP port), grants one at a time in round-robin order, and drives the single PBus target through its request / ready handshake. It returns read data and a one-cycle acknowledge to the granted master, and aborts any transfer that exceeds a timeout.

## Interface
- TIMEOUT, 16: maximum WAIT cycles before a transfer is aborted; range 2..255.
- clk  in  1  clock; all logic on rising edge.
- rst_l  in  1  reset, asynchronous, active-low.
- mN_req  in  1  (N=0,1) transfer request; level, held until mN_ack or mN_err.
- mN_rnw  in  1  1 = read, 0 = write.
- mN_addr  in  5  halfword address, bits [5:1].
- mN_wdata  in  16  write data.
- mN_be  in  2  byte enables; bit0 = [7:0], bit1 = [15:8].
- mN_ack  out  1  one-cycle completion pulse.
- mN_err  out  1  one-cycle timeout pulse; mutually exclusive with mN_ack.
- mN_rdata  out  16  read data; valid with mN_ack, held until the next completion to that master.
- s_addr  out  5  to PBusAddr.
- s_wdata  out  16  to PBusDataIn.
- s_be  out  2  to PBusBE.
- s_req  out  2  to PBusReq; bit0 = start strobe, bit1 = read (1) / write (0).
- s_rdata  in  16  from PBusDataOut; combinational on s_addr.
- s_rdy  in  1  from PBusRdy.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, RELEASE.
- **IDLE:** with s_rdy=1 and any mN_req=1, latch the winner's rnw/addr/wdata/be into the command register and record `gnt`. Go to ISSUE. Otherwise stay in IDLE.
- **Round-robin:** when both masters request, grant the master that is not `last`. `last` updates on every grant. At reset `last`=1, so master 0 wins the first tie.
- **ISSUE:** s_req[0]=1 for exactly this one cycle. Clear the timeout counter and `seen_low`. Go to WAIT.
- **WAIT:**
  - s_rdy=0 sets `seen_low`.
  - s_rdy=1 with `seen_low` set: capture s_rdata into mN_rdata[gnt] if rnw. Go to RELEASE with result OK.
  - Counter reaches TIMEOUT: go to RELEASE with result ERR.
- **RELEASE:** pulse mN_ack[gnt] or mN_err[gnt]. Return to IDLE.
- **Command register:** s_addr, s_wdata, s_be and s_req[1] come from the command register. They stay stable from ISSUE through RELEASE.
- **Master changes mid-transfer:** if the master drops mN_req or changes its fields mid-transfer, ignore it. The transfer completes and is still acknowledged.
- **Request sampling:** mN_req is sampled only in IDLE. A request still high in the IDLE cycle after the ack is treated as a new transfer.
- **Reset:** reset mid-transfer returns to IDLE with all outputs 0. The slave is reset by the same rst_l.
- **Reset values:** all outputs 0; mN_rdata=16'h0000; state=IDLE; last=1.

## Timing
- **Read or write, uncontended:** mN_req high in IDLE at cycle 0 gives:
  - cycle 1: ISSUE (s_req[0]=1);
  - cycle 2: WAIT (slave busy, s_rdy=0; a write commits at the end of this cycle);
  - cycle 3: WAIT (s_rdy=1, data captured);
  - cycle 4: RELEASE (mN_ack=1);
  - cycle 5: IDLE.
- **Latency and throughput:** 4 cycles from request to ack; one transfer per 5 cycles back-to-back.
- **Guard gap:** the gap cycle guarantees the slave has returned to its idle state before the next strobe.
- **Timeout:** with s_rdy stuck at 0, mN_err pulses at cycle TIMEOUT+3. The default TIMEOUT=16 gives cycle 19.
- **Outputs:** all registered; no combinational path from mN_* to s_* or from s_* to mN_*.

## Structure
- **Package pbus_pkg:** state encoding (2-bit), PBus request bit positions (REQ_STROBE=0, REQ_READ=1), and the command struct {rnw, addr[5:1], wdata[15:0], be[1:0]}.
- **Sub-module rr_arb2:** two-input round-robin grant with the `last` pointer. It is instantiated once; the FSM, command register and timeout counter stay in pbus_arbiter.

## Test plan
- **Single write:** m0 writes addr 5'h02, data 16'hA5C3, be 2'b11. Required: s_req=2'b01 for one cycle; m0_ack at cycle 4; a later read returns 16'hA5C3.
- **Contention:** m0 and m1 request together from reset. Required: m0 granted first and m1 second; under continuous requests the grants alternate m0, m1, m0, m1; acks at cycles 4 and 9.
- **Byte-lane read-back:** m1 writes addr 5'h00, data 16'h1234, be 2'b01, then reads addr 5'h00. Required: m1_rdata=16'h0034 if the register was 0; m0_rdata unchanged.
- **Timeout:** slave model holds s_rdy=0 after the strobe, TIMEOUT=16. Required: m0_err at cycle 19; no m0_ack; the next request proceeds normally.
- **Reset mid-WAIT:** assert rst_l low in cycle 2. Required: all outputs 0 immediately; the FSM is in IDLE after release and the next transfer completes in 4 cycles.
- **Request withdrawn after ISSUE:** m0_req drops after ISSUE. Required: the transfer completes and m0_ack still pulses at cycle 4.
